// File: rtl/jk_pkg.sv
`default_nettype none
// ============================================================================
// Module  : jk_pkg
// Brief   : Shared command op encodings and sequencer FSM states for JK stages
// Revision: 1.0
// ============================================================================
package jk_pkg;

    localparam logic [1:0] OP_LOAD   = 2'b00;
    localparam logic [1:0] OP_UP     = 2'b01;
    localparam logic [1:0] OP_DOWN   = 2'b10;
    localparam logic [1:0] OP_TOGGLE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STEP   = 2'd1,
        ST_SETTLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/jk_excite.sv
`default_nettype none
// ============================================================================
// Module  : jk_excite
// Brief   : Combinational J/K excitation from an op, its operand and current Q
// Revision: 1.0
// ============================================================================
module jk_excite #(
    parameter int WIDTH = 4
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] data,
    input  logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k
);
    import jk_pkg::*;

    logic [WIDTH-1:0] w_target;

    always_comb begin
        w_target = data;
        j        = '0;
        k        = '0;
        case (op)
            OP_LOAD:   w_target = data;
            OP_UP:     w_target = q + WIDTH'(1);
            OP_DOWN:   w_target = q - WIDTH'(1);
            default:   w_target = data;
        endcase
        // TOGGLE drives j=k directly; every other op moves Q toward the target
        if (op == OP_TOGGLE) begin
            j = data;
            k = data;
        end else begin
            j = w_target & ~q;
            k = ~w_target & q;
        end
    end

endmodule
`default_nettype wire

// File: rtl/jk_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : jk_cmd_sequencer
// Brief   : Turns LOAD/UP/DOWN/TOGGLE commands into stepped J/K bank excitation
// Revision: 1.0
// ============================================================================
module jk_cmd_sequencer #(
    parameter int WIDTH  = 4,
    parameter int REPS_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [WIDTH-1:0]  cmd_data,
    input  logic [REPS_W-1:0] cmd_reps,
    input  logic [WIDTH-1:0]  q_fb,
    output logic [WIDTH-1:0]  j_out,
    output logic [WIDTH-1:0]  k_out,
    output logic              jk_strobe,
    output logic              busy,
    output logic              done
);
    import jk_pkg::*;

    state_t            r_state;
    logic [1:0]        r_op;
    logic [WIDTH-1:0]  r_data;
    logic [REPS_W-1:0] r_cnt;

    logic [1:0]        w_op;
    logic [WIDTH-1:0]  w_data;
    logic [WIDTH-1:0]  w_j;
    logic [WIDTH-1:0]  w_k;
    logic              w_multi;

    assign cmd_ready = (r_state == ST_IDLE);

    // The first step is registered on the accept edge, before the latched copy exists
    assign w_op    = (r_state == ST_IDLE) ? cmd_op   : r_op;
    assign w_data  = (r_state == ST_IDLE) ? cmd_data : r_data;
    assign w_multi = (cmd_op == OP_UP) || (cmd_op == OP_DOWN);

    jk_excite #(
        .WIDTH (WIDTH)
    ) u_excite (
        .op   (w_op),
        .data (w_data),
        .q    (q_fb),
        .j    (w_j),
        .k    (w_k)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_op      <= OP_LOAD;
            r_data    <= '0;
            r_cnt     <= '0;
            j_out     <= '0;
            k_out     <= '0;
            jk_strobe <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            j_out     <= '0;
            k_out     <= '0;
            jk_strobe <= 1'b0;
            done      <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_op   <= cmd_op;
                        r_data <= cmd_data;
                        busy   <= 1'b1;
                        if (w_multi && (cmd_reps == '0)) begin
                            r_state <= ST_DONE;
                            done    <= 1'b1;
                        end else begin
                            r_state   <= ST_STEP;
                            r_cnt     <= w_multi ? cmd_reps : REPS_W'(1);
                            j_out     <= w_j;
                            k_out     <= w_k;
                            jk_strobe <= 1'b1;
                        end
                    end
                end
                ST_STEP: begin
                    r_cnt   <= r_cnt - REPS_W'(1);
                    r_state <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (r_cnt != '0) begin
                        r_state   <= ST_STEP;
                        j_out     <= w_j;
                        k_out     <= w_k;
                        jk_strobe <= 1'b1;
                    end else begin
                        r_state <= ST_DONE;
                        done    <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_jk_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_jk_cmd_sequencer
// Brief   : Self-checking bench for jk_cmd_sequencer driving a modelled JK bank
// Revision: 1.0
// ============================================================================
module tb_jk_cmd_sequencer;
    import jk_pkg::*;

    localparam int WIDTH  = 4;
    localparam int REPS_W = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [1:0]        cmd_op = 2'b00;
    logic [WIDTH-1:0]  cmd_data = '0;
    logic [REPS_W-1:0] cmd_reps = '0;
    logic [WIDTH-1:0]  q_fb;
    logic [WIDTH-1:0]  j_out;
    logic [WIDTH-1:0]  k_out;
    logic              jk_strobe;
    logic              busy;
    logic              done;

    logic [WIDTH-1:0]  bank;
    logic              bank_load = 1'b0;
    logic [WIDTH-1:0]  bank_val = '0;
    logic [WIDTH-1:0]  q_exp;
    int                tests = 0;
    int                fails = 0;

    always #5 clk = ~clk;

    jk_cmd_sequencer #(
        .WIDTH  (WIDTH),
        .REPS_W (REPS_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_reps  (cmd_reps),
        .q_fb      (q_fb),
        .j_out     (j_out),
        .k_out     (k_out),
        .jk_strobe (jk_strobe),
        .busy      (busy),
        .done      (done)
    );

    // JK bank: per bit 10 set, 01 clear, 11 toggle, 00 hold
    assign q_fb = bank;
    always @(posedge clk) begin
        if (bank_load)
            bank <= bank_val;
        else if (jk_strobe)
            bank <= (j_out & ~bank) | (~k_out & bank);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] next_q(input logic [1:0] op, input logic [WIDTH-1:0] data,
                                                 input logic [WIDTH-1:0] q);
        int v;
        case (op)
            OP_LOAD: v = int'(data);
            OP_UP:   v = (int'(q) + 1) % 16;
            OP_DOWN: v = (int'(q) + 15) % 16;
            default: v = int'(q ^ data);
        endcase
        return WIDTH'(v);
    endfunction

    function automatic logic [2*WIDTH-1:0] exp_jk(input logic [1:0] op, input logic [WIDTH-1:0] data,
                                                  input logic [WIDTH-1:0] q);
        logic [WIDTH-1:0] t;
        if (op == OP_TOGGLE) return {data, data};
        t = next_q(op, data, q);
        return {t & ~q, ~t & q};
    endfunction

    task automatic set_bank(input logic [WIDTH-1:0] v);
        @(negedge clk);
        bank_load = 1'b1;
        bank_val  = v;
        @(negedge clk);
        bank_load = 1'b0;
        q_exp     = v;
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [WIDTH-1:0] data, input logic [REPS_W-1:0] reps);
        int n;
        logic s_exp;
        logic [WIDTH-1:0] q;
        logic [2*WIDTH-1:0] jk;
        n = (op == OP_UP || op == OP_DOWN) ? int'(reps) : 1;
        @(negedge clk);
        chk("ready_idle", {31'b0, cmd_ready}, 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        cmd_reps  = reps;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_data  = WIDTH'($urandom);
        cmd_reps  = REPS_W'($urandom);
        q = q_exp;
        for (int c = 1; c <= 2 * n + 1; c++) begin
            @(negedge clk);
            s_exp = (c % 2 == 1) && (c < 2 * n + 1);
            chk("strobe", {31'b0, jk_strobe}, {31'b0, s_exp});
            chk("busy", {31'b0, busy}, 1);
            chk("ready_busy", {31'b0, cmd_ready}, 0);
            chk("done", {31'b0, done}, (c == 2 * n + 1) ? 1 : 0);
            if (s_exp) begin
                jk = exp_jk(op, data, q);
                chk("j_step", {28'b0, j_out}, {28'b0, jk[2*WIDTH-1:WIDTH]});
                chk("k_step", {28'b0, k_out}, {28'b0, jk[WIDTH-1:0]});
                q = next_q(op, data, q);
            end else begin
                chk("jk_idle", {24'b0, j_out, k_out}, 0);
            end
        end
        @(negedge clk);
        chk("busy_end", {31'b0, busy}, 0);
        chk("done_end", {31'b0, done}, 0);
        chk("bank_q", {28'b0, bank}, {28'b0, q});
        q_exp = q;
    endtask

    // Reset lands on the negedge of cycle ca after accept of a 4-step UP
    task automatic abort_at(input int ca, input logic [WIDTH-1:0] start);
        set_bank(start);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = OP_UP;
        cmd_reps  = 4'd4;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        for (int c = 1; c <= ca; c++) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_jk", {24'b0, j_out, k_out}, 0);
        chk("rst_strobe", {31'b0, jk_strobe}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_done", {31'b0, done}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("abort_nodone", {31'b0, done}, 0);
        end
        chk("abort_ready", {31'b0, cmd_ready}, 1);
        q_exp = WIDTH'((int'(start) + ca / 2) % 16);
        chk("abort_bank", {28'b0, bank}, {28'b0, q_exp});
    endtask

    initial begin
        logic [2*WIDTH-1:0] jk;
        @(negedge clk);
        @(negedge clk);
        chk("reset_jk", {24'b0, j_out, k_out}, 0);
        chk("reset_flags", {29'b0, jk_strobe, busy, done}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_ready", {31'b0, cmd_ready}, 1);

        set_bank(4'h3);  run_cmd(OP_LOAD, 4'hA, 4'd0);
        set_bank(4'hE);  run_cmd(OP_UP, 4'h0, 4'd3);
        set_bank(4'h0);  run_cmd(OP_DOWN, 4'h7, 4'd1);
        set_bank(4'h6);  run_cmd(OP_TOGGLE, 4'h5, 4'd9);
        run_cmd(OP_UP, 4'h0, 4'd0);

        // valid held high through a reps=0 command: second accept follows done
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = OP_UP;
        cmd_reps  = 4'd0;
        @(posedge clk);
        #1;
        cmd_op    = OP_LOAD;
        cmd_data  = 4'h5;
        @(negedge clk);
        chk("hold_done", {31'b0, done}, 1);
        chk("hold_nostrobe", {31'b0, jk_strobe}, 0);
        chk("hold_notready", {31'b0, cmd_ready}, 0);
        @(negedge clk);
        chk("hold_ready", {31'b0, cmd_ready}, 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        jk = exp_jk(OP_LOAD, 4'h5, q_exp);
        chk("hold_strobe", {31'b0, jk_strobe}, 1);
        chk("hold_jk", {24'b0, j_out, k_out}, {24'b0, jk});
        @(negedge clk);
        @(negedge clk);
        chk("hold_done2", {31'b0, done}, 1);
        @(negedge clk);
        q_exp = 4'h5;
        chk("hold_bank", {28'b0, bank}, 4'h5);

        abort_at(2, 4'h2);
        run_cmd(OP_UP, 4'h0, 4'd2);
        abort_at(1, 4'h9);
        run_cmd(OP_DOWN, 4'h0, 4'd2);

        for (int i = 0; i < 24; i++) begin
            if (i % 6 == 0) set_bank(WIDTH'($urandom));
            run_cmd(2'($urandom), WIDTH'($urandom), REPS_W'($urandom_range(0, 6)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
